// File: rtl/sram_loader_if.sv
// rtl/sram_loader_if.sv - stream, SRAM write and status bundle for sram_loader
// Signals:
//   start, in_valid, in_data      -> loader (command and byte stream)
//   in_ready                      <- loader (byte accepted when in_valid & in_ready)
//   fm_ce/fm_we/fm_addr/fm_data   <- loader (sram_fmaps write port)
//   wt_ce/wt_we/wt_addr/wt_data   <- loader (sram_weight write port)
//   busy, done, checksum          <- loader (status)
// Modports: master = stream source / status sink, slave = the loader.
interface sram_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fm_ce;
  logic              fm_we;
  logic [ADDR_W-1:0] fm_addr;
  logic [DATA_W-1:0] fm_data;
  logic              wt_ce;
  logic              wt_we;
  logic [ADDR_W-1:0] wt_addr;
  logic [DATA_W-1:0] wt_data;
  logic              busy;
  logic              done;
  logic [15:0]       checksum;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, fm_ce, fm_we, fm_addr, fm_data,
    input  wt_ce, wt_we, wt_addr, wt_data, busy, done, checksum
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, fm_ce, fm_we, fm_addr, fm_data,
    output wt_ce, wt_we, wt_addr, wt_data, busy, done, checksum
  );
endinterface

// File: rtl/sram_loader.sv
// rtl/sram_loader.sv - streams bytes into sram_fmaps then sram_weight
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - sram_loader_if.slave: start/in_valid/in_data/in_ready stream,
//          fm_* and wt_* SRAM write ports, busy/done/checksum status
module sram_loader #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 6,
  parameter int FMAP_DEPTH   = 64,
  parameter int WEIGHT_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  sram_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_FM = 3'd1;
  localparam logic [2:0] S_LOAD_WT = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] FM_LAST = ADDR_W'(FMAP_DEPTH - 1);
  localparam logic [ADDR_W-1:0] WT_LAST = ADDR_W'(WEIGHT_DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              fm_wr_q, fm_wr_d;
  logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
  logic [DATA_W-1:0] fm_data_q, fm_data_d;
  logic              wt_wr_q, wt_wr_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [DATA_W-1:0] wt_data_q, wt_data_d;

  logic in_ready;
  logic accept;

  assign in_ready = (state_q == S_LOAD_FM) || (state_q == S_LOAD_WT);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    checksum_d = checksum_q;
    fm_wr_d    = 1'b0;
    fm_addr_d  = fm_addr_q;
    fm_data_d  = fm_data_q;
    wt_wr_d    = 1'b0;
    wt_addr_d  = wt_addr_q;
    wt_data_d  = wt_data_q;

    if (accept) begin
      checksum_d = checksum_q + 16'(bus.in_data);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD_FM;
          cnt_d      = '0;
          checksum_d = '0;
        end
      end
      S_LOAD_FM: begin
        if (accept) begin
          fm_wr_d   = 1'b1;
          fm_addr_d = cnt_q;
          fm_data_d = bus.in_data;
          if (cnt_q == FM_LAST) begin
            state_d = S_LOAD_WT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_LOAD_WT: begin
        if (accept) begin
          wt_wr_d   = 1'b1;
          wt_addr_d = cnt_q;
          wt_data_d = bus.in_data;
          if (cnt_q == WT_LAST) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      // The final weight write is on the SRAM port during FLUSH.
      S_FLUSH: state_d = S_DONE;
      // start is deliberately not looked at here; it is taken in the next IDLE cycle.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      checksum_q <= '0;
      fm_wr_q    <= 1'b0;
      fm_addr_q  <= '0;
      fm_data_q  <= '0;
      wt_wr_q    <= 1'b0;
      wt_addr_q  <= '0;
      wt_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      checksum_q <= checksum_d;
      fm_wr_q    <= fm_wr_d;
      fm_addr_q  <= fm_addr_d;
      fm_data_q  <= fm_data_d;
      wt_wr_q    <= wt_wr_d;
      wt_addr_q  <= wt_addr_d;
      wt_data_q  <= wt_data_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.fm_ce    = fm_wr_q;
  assign bus.fm_we    = fm_wr_q;
  assign bus.fm_addr  = fm_addr_q;
  assign bus.fm_data  = fm_data_q;
  assign bus.wt_ce    = wt_wr_q;
  assign bus.wt_we    = wt_wr_q;
  assign bus.wt_addr  = wt_addr_q;
  assign bus.wt_data  = wt_data_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.checksum = checksum_q;

endmodule

// File: tb/tb_sram_loader.sv
// tb/tb_sram_loader.sv - directed self-checking bench for sram_loader
module tb_sram_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_loader_if #(.DATA_W(8), .ADDR_W(6)) bus ();

  sram_loader #(
    .DATA_W(8), .ADDR_W(6), .FMAP_DEPTH(64), .WEIGHT_DEPTH(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fm_mem [64];
  logic [7:0] wt_mem [64];
  int         fm_hits[64];
  int         wt_hits[64];
  int         fm_total = 0;
  int         done_cnt = 0;
  bit         both_ce  = 1'b0;

  // Behavioural SRAM pair: records every write seen on the ports.
  always @(negedge clk) begin
    if (bus.fm_ce && bus.fm_we) begin
      fm_mem[bus.fm_addr] = bus.fm_data;
      fm_hits[bus.fm_addr]++;
      fm_total++;
    end
    if (bus.wt_ce && bus.wt_we) begin
      wt_mem[bus.wt_addr] = bus.wt_data;
      wt_hits[bus.wt_addr]++;
    end
    if (bus.fm_ce && bus.wt_ce) both_ce = 1'b1;
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int pat, input int idx);
    logic [31:0] v;
    v = idx;
    return (pat == 1) ? 8'hFF : v[7:0];
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) begin
      fm_mem[k] = 8'hxx; wt_mem[k] = 8'hxx;
      fm_hits[k] = 0;    wt_hits[k] = 0;
    end
    fm_total = 0;
    done_cnt = 0;
    both_ce  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, ".in_ready"}, 32'(bus.in_ready), 0);
    check({pfx, ".fm_ce"},    32'(bus.fm_ce),    0);
    check({pfx, ".fm_we"},    32'(bus.fm_we),    0);
    check({pfx, ".fm_addr"},  32'(bus.fm_addr),  0);
    check({pfx, ".fm_data"},  32'(bus.fm_data),  0);
    check({pfx, ".wt_ce"},    32'(bus.wt_ce),    0);
    check({pfx, ".wt_we"},    32'(bus.wt_we),    0);
    check({pfx, ".wt_addr"},  32'(bus.wt_addr),  0);
    check({pfx, ".wt_data"},  32'(bus.wt_data),  0);
    check({pfx, ".busy"},     32'(bus.busy),     0);
    check({pfx, ".done"},     32'(bus.done),     0);
    check({pfx, ".checksum"}, 32'(bus.checksum), 0);
  endtask

  task automatic start_load(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".busy_at_start"},     32'(bus.busy),     1);
    check({tag, ".in_ready_at_start"}, 32'(bus.in_ready), 1);
    check({tag, ".checksum_cleared"},  32'(bus.checksum), 0);
  endtask

  // Drives the stream from the first LOAD_FM cycle (cyc=1) until done is seen.
  task automatic run_stream(input string tag, input int pat, input bit toggle,
                            input bit pulse_start, input bit hold_start,
                            input int exp_done, input logic [15:0] exp_sum);
    int  idx  = 0;
    int  cyc  = 1;
    int  dcyc = -1;
    bit  acc;
    while (dcyc < 0 && cyc < 1000) begin
      bus.in_valid = toggle ? cyc[0] : 1'b1;
      bus.in_data  = bus.in_valid ? byte_of(pat, idx) : 8'hA5;
      bus.start    = hold_start | (pulse_start && idx == 20);
      if (bus.done) dcyc = cyc;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = hold_start;
    check({tag, ".done_cycle"},   32'(dcyc),         32'(exp_done));
    check({tag, ".accepts"},      32'(idx),          128);
    check({tag, ".done_pulses"},  32'(done_cnt),     1);
    check({tag, ".checksum"},     32'(bus.checksum), 32'(exp_sum));
    check({tag, ".busy_after"},   32'(bus.busy),     0);
    check({tag, ".done_after"},   32'(bus.done),     0);
    check({tag, ".ready_after"},  32'(bus.in_ready), 0);
    check({tag, ".both_ce"},      32'(both_ce),      0);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("%s.fm[%0d]", tag, k), 32'(fm_mem[k]), 32'(byte_of(pat, k)));
      check($sformatf("%s.fm_hits[%0d]", tag, k), 32'(fm_hits[k]), 1);
      check($sformatf("%s.wt[%0d]", tag, k), 32'(wt_mem[k]), 32'(byte_of(pat, 64 + k)));
      check($sformatf("%s.wt_hits[%0d]", tag, k), 32'(wt_hits[k]), 1);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    tick(); tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("idle");

    // Full load, valid held high: done 130 cycles after start accepted.
    clear_mem();
    start_load("full");
    run_stream("full", 0, 1'b0, 1'b0, 1'b0, 130, 16'h1FC0);

    // Valid toggling every cycle: 128th accept at cycle 255, done at 257.
    clear_mem();
    start_load("toggle");
    run_stream("toggle", 0, 1'b1, 1'b0, 1'b0, 257, 16'h1FC0);

    // Second start pulse during LOAD_FM is ignored.
    clear_mem();
    start_load("restart");
    run_stream("restart", 0, 1'b0, 1'b1, 1'b0, 130, 16'h1FC0);

    // Reset in the cycle that would accept fmaps byte 30.
    clear_mem();
    start_load("rstmid");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.in_data = byte_of(0, i);
      tick();
    end
    bus.in_data = 8'd30;
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_idle_outputs("rstmid");
    check("rstmid.fm_writes", 32'(fm_total), 30);
    check("rstmid.no_done",   32'(done_cnt), 0);
    rst = 1'b0;
    tick();
    clear_mem();
    start_load("reload");
    run_stream("reload", 0, 1'b0, 1'b0, 1'b0, 130, 16'h1FC0);

    // All-0xFF load with start held high, then an immediate back-to-back load.
    clear_mem();
    start_load("ff");
    run_stream("ff", 1, 1'b0, 1'b0, 1'b1, 130, 16'h7F80);
    tick();
    bus.start = 1'b0;
    check("b2b.busy",     32'(bus.busy),     1);
    check("b2b.in_ready", 32'(bus.in_ready), 1);
    check("b2b.checksum", 32'(bus.checksum), 0);
    clear_mem();
    run_stream("b2b", 0, 1'b0, 1'b0, 1'b0, 130, 16'h1FC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
